// File: rtl/sdpram_pkg.sv
// Shared types and the byte-strobe merge helper for the pipelined simple dual-port RAM.
package sdpram_pkg;

  localparam int MAX_DATA_WIDTH = 1024;
  localparam int MAX_STRB_WIDTH = MAX_DATA_WIDTH / 8;

  typedef enum logic {
    RDW_OLD = 1'b0,
    RDW_NEW = 1'b1
  } rdw_mode_e;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Bytes enabled in strb come from new_word, all others from old_word; only data_width/8 bytes are considered.
  function automatic logic [MAX_DATA_WIDTH-1:0] strb_merge(
    input logic [MAX_DATA_WIDTH-1:0] old_word,
    input logic [MAX_DATA_WIDTH-1:0] new_word,
    input logic [MAX_STRB_WIDTH-1:0] strb,
    input int                        data_width
  );
    logic [MAX_DATA_WIDTH-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MAX_STRB_WIDTH; i++) begin
      if ((i < (data_width / 8)) && strb[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        merged[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/sdpram_rd_pipe.sv
// Extra read-latency delay line carrying {valid, coll, data}; collapses to wires when STAGES is 0.
module sdpram_rd_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int STAGES     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic                  coll_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  output logic                  coll_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  if (STAGES == 0) begin : g_wire
    logic unused_s;
    assign unused_s = ^{clk, rst};
    assign valid_o  = valid_i;
    assign coll_o   = coll_i;
    assign data_o   = data_i;
  end else begin : g_pipe
    logic [STAGES-1:0]     valid_q;
    logic [STAGES-1:0]     coll_q;
    logic [DATA_WIDTH-1:0] data_q [STAGES];

    // Control bits are reset so that rst discards every read still in flight.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= '0;
        coll_q  <= '0;
      end else begin
        valid_q[0] <= valid_i;
        coll_q[0]  <= coll_i;
        for (int i = 1; i < STAGES; i++) begin
          valid_q[i] <= valid_q[i-1];
          coll_q[i]  <= coll_q[i-1];
        end
      end
    end

    // The input stage only changes on a read, so shifting freely keeps the output stable between reads.
    always_ff @(posedge clk) begin
      data_q[0] <= data_i;
      for (int i = 1; i < STAGES; i++) begin
        data_q[i] <= data_q[i-1];
      end
    end

    assign valid_o = valid_q[STAGES-1];
    assign coll_o  = coll_q[STAGES-1];
    assign data_o  = data_q[STAGES-1];
  end

endmodule

// File: rtl/sdpram_pipe.sv
// Simple dual-port RAM with byte-strobed write port, pipelined read port, selectable
// read-during-write policy, collision flag and a zeroing sweep after reset.
module sdpram_pipe
  import sdpram_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_DEPTH    = 1024,
  parameter int ADDR_WIDTH   = $clog2(MEM_DEPTH),
  parameter int STRB_WIDTH   = DATA_WIDTH / 8,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STRB_WIDTH-1:0] wena,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  input  logic                  renb,
  input  logic [ADDR_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0] doutb,
  output logic                  doutb_valid,
  output logic                  coll,
  output logic                  init_done
);

  localparam rdw_mode_e             RDW_L     = (RDW_MODE == 1) ? RDW_NEW : RDW_OLD;
  localparam logic [ADDR_WIDTH:0]   DEPTH_L   = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  state_e                state_q;
  logic [ADDR_WIDTH-1:0] init_cnt_q;
  logic                  init_done_q;

  logic                  rd_valid_q;
  logic                  rd_coll_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] rd_word_d;

  logic run_s;
  logic addra_ok_s;
  logic addrb_ok_s;
  logic wr_en_s;
  logic rd_en_s;
  logic coll_s;

  assign run_s      = (state_q == RUN);
  assign addra_ok_s = ({1'b0, addra} < DEPTH_L);
  assign addrb_ok_s = ({1'b0, addrb} < DEPTH_L);
  assign wr_en_s    = run_s && (wena != '0) && addra_ok_s;
  assign rd_en_s    = run_s && renb;
  assign coll_s     = rd_en_s && (wena != '0) && (addra == addrb);

  // Sweep FSM: zero one word per cycle, then go live.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          if (init_cnt_q == LAST_ADDR) begin
            state_q     <= RUN;
            init_cnt_q  <= '0;
            init_done_q <= 1'b1;
          end else begin
            init_cnt_q  <= init_cnt_q + ADDR_WIDTH'(1);
          end
        end
        RUN: begin
          init_done_q <= 1'b1;
        end
        default: begin
          state_q     <= INIT;
          init_cnt_q  <= '0;
          init_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Array write: the sweep owns the array in INIT, port A owns it in RUN.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == INIT)) begin
      mem_q[init_cnt_q] <= '0;
    end else if (!rst && wr_en_s) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (wena[b]) begin
          mem_q[addra][8*b +: 8] <= dina[8*b +: 8];
        end
      end
    end
  end

  // Read word selection, including the new-data bypass on a same-address write.
  always_comb begin
    rd_word_d = '0;
    if (!addrb_ok_s) begin
      rd_word_d = '0;
    end else if (coll_s && (RDW_L == RDW_NEW)) begin
      rd_word_d = DATA_WIDTH'(strb_merge(MAX_DATA_WIDTH'(mem_q[addrb]),
                                         MAX_DATA_WIDTH'(dina),
                                         MAX_STRB_WIDTH'(wena),
                                         DATA_WIDTH));
    end else begin
      rd_word_d = mem_q[addrb];
    end
  end

  // First read stage; data only moves on a launched read so it holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_coll_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_en_s;
      rd_coll_q  <= coll_s;
      if (rd_en_s) begin
        rd_data_q <= rd_word_d;
      end
    end
  end

  sdpram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .STAGES     (READ_LATENCY - 1)
  ) u_rd_pipe (
    .clk     (clk),
    .rst     (rst),
    .valid_i (rd_valid_q),
    .coll_i  (rd_coll_q),
    .data_i  (rd_data_q),
    .valid_o (doutb_valid),
    .coll_o  (coll),
    .data_o  (doutb)
  );

  assign init_done = init_done_q;

endmodule

// File: tb/tb_sdpram_pipe.sv
// Directed bench: four sdpram_pipe instances sharing stimulus (latency 1, latency 2 old/new RDW, latency 4).
module tb_sdpram_pipe;

  logic        clk;
  logic        rst;
  logic [3:0]  wena;
  logic [3:0]  addra;
  logic [31:0] dina;
  logic        renb;
  logic [3:0]  addrb;

  // Instance order: 0 = RL1/old, 1 = RL2/old, 2 = RL2/new, 3 = RL4/old.
  logic [31:0] dout [4];
  logic        vld  [4];
  logic        col  [4];
  logic        done [4];

  int n_asserts = 0;
  int n_fail    = 0;

  sdpram_pipe #(.DATA_WIDTH(32), .MEM_DEPTH(16), .READ_LATENCY(1), .RDW_MODE(0)) u_l1 (
    .clk(clk), .rst(rst), .wena(wena), .addra(addra), .dina(dina), .renb(renb), .addrb(addrb),
    .doutb(dout[0]), .doutb_valid(vld[0]), .coll(col[0]), .init_done(done[0]));
  sdpram_pipe #(.DATA_WIDTH(32), .MEM_DEPTH(16), .READ_LATENCY(2), .RDW_MODE(0)) u_m0 (
    .clk(clk), .rst(rst), .wena(wena), .addra(addra), .dina(dina), .renb(renb), .addrb(addrb),
    .doutb(dout[1]), .doutb_valid(vld[1]), .coll(col[1]), .init_done(done[1]));
  sdpram_pipe #(.DATA_WIDTH(32), .MEM_DEPTH(16), .READ_LATENCY(2), .RDW_MODE(1)) u_m1 (
    .clk(clk), .rst(rst), .wena(wena), .addra(addra), .dina(dina), .renb(renb), .addrb(addrb),
    .doutb(dout[2]), .doutb_valid(vld[2]), .coll(col[2]), .init_done(done[2]));
  sdpram_pipe #(.DATA_WIDTH(32), .MEM_DEPTH(16), .READ_LATENCY(4), .RDW_MODE(0)) u_l4 (
    .clk(clk), .rst(rst), .wena(wena), .addra(addra), .dina(dina), .renb(renb), .addrb(addrb),
    .doutb(dout[3]), .doutb_valid(vld[3]), .coll(col[3]), .init_done(done[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_read(input int i, input string tag, input logic [31:0] exp_d, input logic exp_c);
    chk($sformatf("%s_valid[%0d]", tag, i), 32'(vld[i]), 32'd1);
    chk($sformatf("%s_data[%0d]", tag, i), dout[i], exp_d);
    chk($sformatf("%s_coll[%0d]", tag, i), 32'(col[i]), 32'(exp_c));
  endtask

  task automatic chk_idle(input int i, input string tag);
    chk($sformatf("%s_idle[%0d]", tag, i), 32'(vld[i]), 32'd0);
  endtask

  task automatic write_word(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    wena = s; addra = a; dina = d;
    tick();
    wena = 4'h0;
  endtask

  // Read (optionally with a same-cycle write) and check every instance at its own latency.
  task automatic do_read(input string tag, input logic [3:0] a, input logic [3:0] s, input logic [31:0] d,
                         input logic [31:0] exp_old, input logic [31:0] exp_new, input logic exp_c);
    renb = 1'b1; addrb = a; wena = s; addra = a; dina = d;
    tick();
    renb = 1'b0; wena = 4'h0;
    chk_read(0, tag, exp_old, exp_c);
    chk_idle(1, tag);
    tick();
    chk_idle(0, tag);
    chk_read(1, tag, exp_old, exp_c);
    chk_read(2, tag, exp_new, exp_c);
    tick();
    chk_idle(1, tag);
    chk_idle(3, tag);
    tick();
    chk_read(3, tag, exp_old, exp_c);
  endtask

  function automatic logic [31:0] stream_word(input int a);
    return 32'hC0DE_0000 + (32'(a) * 32'h0000_0101);
  endfunction

  initial begin
    int lat [4];
    lat[0] = 1; lat[1] = 2; lat[2] = 2; lat[3] = 4;
    rst = 1'b1; wena = 4'h0; addra = 4'h0; dina = 32'h0; renb = 1'b0; addrb = 4'h0;
    repeat (5) tick();

    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_init_done[%0d]", i), 32'(done[i]), 32'd0);
      chk($sformatf("rst_valid[%0d]", i), 32'(vld[i]), 32'd0);
      chk($sformatf("rst_coll[%0d]", i), 32'(col[i]), 32'd0);
      chk($sformatf("rst_doutb[%0d]", i), dout[i], 32'h0);
    end

    // Sweep: init_done rises exactly 16 cycles after rst falls.
    rst = 1'b0;
    repeat (15) tick();
    chk("sweep_cyc15", 32'(done[1]), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) chk($sformatf("sweep_cyc16[%0d]", i), 32'(done[i]), 32'd1);

    do_read("init_rd5", 4'd5, 4'h0, 32'h0, 32'h0000_0000, 32'h0000_0000, 1'b0);

    write_word(4'd3, 32'hDEAD_BEEF, 4'hF);
    do_read("full_wr", 4'd3, 4'h0, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);

    write_word(4'd3, 32'h1122_3344, 4'b0101);
    do_read("strobe", 4'd3, 4'h0, 32'h0, 32'hDE22_BE44, 32'hDE22_BE44, 1'b0);

    write_word(4'd7, 32'hAAAA_AAAA, 4'hF);
    do_read("collide", 4'd7, 4'b0011, 32'h5555_5555, 32'hAAAA_AAAA, 32'hAAAA_5555, 1'b1);
    do_read("after_coll", 4'd7, 4'h0, 32'h0, 32'hAAAA_5555, 32'hAAAA_5555, 1'b0);

    // Streaming: back-to-back reads of every word, checked per latency.
    for (int a = 0; a < 16; a++) write_word(4'(a), stream_word(a), 4'hF);
    for (int t = 0; t < 20; t++) begin
      renb  = (t < 16);
      addrb = 4'(t);
      tick();
      for (int i = 0; i < 4; i++) begin
        int idx;
        idx = t - (lat[i] - 1);
        if (idx >= 0 && idx < 16) begin
          chk_read(i, $sformatf("stream%0d", idx), stream_word(idx), 1'b0);
        end else begin
          chk_idle(i, $sformatf("stream_t%0d", t));
        end
      end
    end
    renb = 1'b0;

    // Reset with reads in flight: nothing may emerge afterwards.
    renb = 1'b1; addrb = 4'd1;
    tick();
    addrb = 4'd2;
    tick();
    renb = 1'b0; rst = 1'b1;
    repeat (2) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        chk_idle(i, "rst_flight");
        chk($sformatf("rst_flight_done[%0d]", i), 32'(done[i]), 32'd0);
      end
    end
    rst = 1'b0;

    // During INIT, port activity must be ignored.
    for (int k = 0; k < 16; k++) begin
      wena = 4'hF; addra = 4'd2; dina = 32'h1234_5678; renb = 1'b1; addrb = 4'd2;
      tick();
      for (int i = 0; i < 4; i++) chk_idle(i, $sformatf("init_gate%0d", k));
    end
    wena = 4'h0; renb = 1'b0;
    chk("init_gate_done", 32'(done[3]), 32'd1);
    do_read("init_gate_rd2", 4'd2, 4'h0, 32'h0, 32'h0000_0000, 32'h0000_0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/sdpram_pipe.md
# sdpram_pipe

Parametrised successor to the simple dual-port RAM: one write port (A) with byte strobes, one read port (B) with a configurable output pipeline. It adds a read-valid flag, a selectable read-during-write policy, collision reporting and a reset-driven zero-initialisation sweep. It is the default on-chip buffer for datapath blocks that need deterministic contents after reset and a known read latency.

## Interface

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- MEM_DEPTH, 1024, number of words; need not be a power of 2.
- ADDR_WIDTH, $clog2(MEM_DEPTH), derived address width.
- STRB_WIDTH, DATA_WIDTH/8, derived byte-strobe width.
- READ_LATENCY, 1, cycles from read request to data; legal values 1 to 4.
- RDW_MODE, 0, same-address read-during-write policy: 0 returns old data, 1 returns new merged data.

Ports:
- clk, in, 1, single clock; all logic on the rising edge.
- rst, in, 1, synchronous, active-high reset.
- wena, in, STRB_WIDTH, per-byte write enable for port A; all-zero means no write.
- addra, in, ADDR_WIDTH, write address.
- dina, in, DATA_WIDTH, write data.
- renb, in, 1, read request for port B.
- addrb, in, ADDR_WIDTH, read address.
- doutb, out, DATA_WIDTH, read data.
- doutb_valid, out, 1, doutb carries the result of a read request.
- coll, out, 1, the read being returned collided with a same-cycle write to the same address.
- init_done, out, 1, the zero-initialisation sweep is complete and ports are live.

## Operation

- FSM states are INIT and RUN.
  - rst forces INIT and clears the sweep counter.
  - INIT writes zero to word init_cnt each cycle, from 0 to MEM_DEPTH-1.
  - After the last word is written, INIT moves to RUN and init_done rises.
  - rst in any state returns to INIT and restarts the sweep at 0.
- In INIT, wena and renb are ignored: no writes are accepted and no reads are launched.
- Write, in RUN:
  - Byte i of mem[addra] takes dina[8i+7:8i] when wena[i] is 1; other bytes are unchanged.
  - addra >= MEM_DEPTH: the write is dropped.
- Read, in RUN with renb=1:
  - The array is read at addrb and the result enters the pipeline.
  - addrb >= MEM_DEPTH: doutb is 0 and the result is still marked valid.
- Collision: renb=1, wena≠0 and addra==addrb in the same RUN cycle.
  - RDW_MODE 0: the read returns pre-write contents.
  - RDW_MODE 1: the read returns a per-byte merge of dina where wena=1 and old data elsewhere.
  - coll=1 is returned alongside that read's doutb_valid.
- doutb holds its last valid value while doutb_valid=0.
- Throughput is one read and one write per cycle, with no bubbles.

## Timing

- Reset values: doutb=0, doutb_valid=0, coll=0, init_done=0, all pipeline stages invalid.
- Sweep length:
  - With rst deasserted at cycle 0, the sweep writes words in cycles 0 to MEM_DEPTH-1.
  - init_done=1 from cycle MEM_DEPTH onward.
- Read latency:
  - A read sampled in cycle n produces doutb, doutb_valid and coll in cycle n+READ_LATENCY, each for exactly one cycle per request.
  - READ_LATENCY=1 is a registered array read.
  - Each additional cycle is one register stage on data, valid and coll together.
- Write visibility: a write in cycle n is visible to a non-colliding read issued in cycle n+1 or later.
- rst mid-operation: all in-flight reads are discarded, and no doutb_valid pulse appears for them after rst.

## Structure

- Package sdpram_pkg contains:
  - rdw_mode_e enum: RDW_OLD=0, RDW_NEW=1.
  - state_e enum: INIT, RUN.
  - Function strb_merge(old, new, strb), parametrised via DATA_WIDTH.
- Sub-module sdpram_rd_pipe holds the READ_LATENCY-1 stage delay line for {valid, coll, data}.
  - It has synchronous reset on valid and coll only.
  - At READ_LATENCY=1 it reduces to wires.
- The top level holds the array, the FSM with init_cnt, write-strobe logic and collision detection.

## Test plan

All scenarios use DATA_WIDTH=32, MEM_DEPTH=16, READ_LATENCY=2 unless noted.
- Init sweep: pulse rst, then release it → init_done rises exactly 16 cycles later. A read of address 5 returns 0x00000000 with valid 2 cycles after the request.
- Full write and read: write 0xDEADBEEF to address 3 with wena=4'hF, read address 3 → doutb=0xDEADBEEF, valid at n+2, coll=0.
- Byte strobes: on the preceding state, write 0x11223344 to address 3 with wena=4'b0101 → a read of address 3 returns 0xDE22BE44.
- Collision in both modes: address 7 holds 0xAAAAAAAA; in the same cycle, write 0x55555555 with wena=4'b0011 and read address 7 → RDW_MODE 0 returns 0xAAAAAAAA, RDW_MODE 1 returns 0xAAAA5555. Both modes assert coll=1. A follow-up read returns 0xAAAA5555.
- Streaming: issue renb every cycle for addresses 0 to 15 → 16 consecutive valid cycles with data in order. Repeat with READ_LATENCY=1 and 4 and check the corresponding shift.
- Reset and init gating, two parts:
  - Assert rst while 2 reads are in flight → no doutb_valid pulses follow for them.
  - During the subsequent INIT, write 0x12345678 to address 2 → after init_done, a read of address 2 returns 0x00000000.
